// File: rtl/ffdiv_issue.sv
// Operand issue/collect sequencer for the FP divider core: queues operand pairs,
// issues one at a time, captures the result. Optional watchdog: FFDIV_ISSUE_TIMEOUT_EN.
module ffdiv_issue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned OPW     = 32,
  parameter int unsigned FLW     = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPW-1:0]             in_op1,
  input  logic [OPW-1:0]             in_op2,
  output logic                       core_en,
  output logic [OPW-1:0]             core_op1,
  output logic [OPW-1:0]             core_op2,
  input  logic                       core_ready,
  input  logic [OPW-1:0]             core_result,
  input  logic [FLW-1:0]             core_flag,
  input  logic [$clog2(OPW)-1:0]     core_itr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPW-1:0]             out_result,
  output logic [FLW-1:0]             out_flag,
  output logic [$clog2(OPW)-1:0]     out_itr,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(OPW);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t           r_state, w_next;
  logic [OPW-1:0]   r_mem_op1 [DEPTH];
  logic [OPW-1:0]   r_mem_op2 [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count, w_count_next;
  logic             r_in_ready, r_core_en, r_out_valid, r_busy, r_wait_first;
  logic [OPW-1:0]   r_core_op1, r_core_op2, r_out_result;
  logic [FLW-1:0]   r_out_flag;
  logic [IW-1:0]    r_out_itr;
  logic             w_push, w_pop, w_load, w_capture;

`ifdef FFDIV_ISSUE_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0]   r_wait_cnt;
  logic             w_timeout;
`endif

  assign w_push       = in_valid & r_in_ready;
  assign w_pop        = (r_state == S_ISSUE);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // Next-state and capture decisions
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_capture = 1'b0;
`ifdef FFDIV_ISSUE_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && core_ready) begin
          w_next = S_ISSUE;
          w_load = 1'b1;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        // core_ready may still be high from before the start in the first WAIT cycle
        if (!r_wait_first && core_ready) begin
          w_next    = S_OUT;
          w_capture = 1'b1;
        end
`ifdef FFDIV_ISSUE_TIMEOUT_EN
        else if (r_wait_cnt == TCW'(TIMEOUT - 1)) begin
          w_next    = S_OUT;
          w_timeout = 1'b1;
        end
`endif
      end
      S_OUT: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op1[r_wr_ptr] <= in_op1;
      r_mem_op2[r_wr_ptr] <= in_op2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_in_ready   <= 1'b1;
      r_core_en    <= 1'b0;
      r_core_op1   <= '0;
      r_core_op2   <= '0;
      r_wait_first <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flag   <= '0;
      r_out_itr    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count      <= w_count_next;
      r_in_ready   <= (w_count_next != CW'(DEPTH));
      r_core_en    <= (w_next == S_ISSUE);
      if (w_load) begin
        r_core_op1 <= r_mem_op1[r_rd_ptr];
        r_core_op2 <= r_mem_op2[r_rd_ptr];
      end
      r_wait_first <= (r_state == S_ISSUE);
      if (w_capture) begin
        r_out_result <= core_result;
        r_out_flag   <= core_flag;
        r_out_itr    <= core_itr;
      end
`ifdef FFDIV_ISSUE_TIMEOUT_EN
      // Watchdog substitutes a quiet NaN with only the nanf flag set
      if (w_timeout) begin
        r_out_result <= OPW'(32'h7FC0_0000);
        r_out_flag   <= FLW'(1) << (FLW - 1);
        r_out_itr    <= '0;
      end
`endif
      r_out_valid  <= (w_next == S_OUT);
      r_busy       <= (w_next != S_IDLE);
    end
  end

`ifdef FFDIV_ISSUE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_wait_cnt <= '0;
    else if (r_state == S_ISSUE) r_wait_cnt <= '0;
    else if (r_state == S_WAIT)  r_wait_cnt <= r_wait_cnt + TCW'(1);
  end
`endif

  assign in_ready   = r_in_ready;
  assign core_en    = r_core_en;
  assign core_op1   = r_core_op1;
  assign core_op2   = r_core_op2;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_flag   = r_out_flag;
  assign out_itr    = r_out_itr;
  assign occupancy  = r_count;
  assign busy       = r_busy;

endmodule
